// File: rtl/rr_req_grant_arbiter.sv
// rr_req_grant_arbiter
//   Responder side of the req/grant handshake. Samples NUM_REQ level-sensitive
//   request lines and returns a registered one-hot grant, arbitrated
//   round-robin with a bounded hold time. A lone requester sees its grant one
//   edge after its request is first sampled.
//
// Ports
//   clk         : single clock, all logic on posedge
//   rst_n       : asynchronous active-low reset
//   req         : request lines, bit i = requester i
//   grant       : registered one-hot grant, all-zero when idle
//   grant_valid : registered OR of grant
//   grant_id    : index of current owner, 0 when grant_valid = 0
//   hold_cnt    : cycles the current owner has held grant, saturating at MAX_HOLD
module rr_req_grant_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            grant_valid,
  output logic [ID_W-1:0]                 grant_id,
  output logic [$clog2(MAX_HOLD+1)-1:0]   hold_cnt
);

  localparam int unsigned HOLD_W  = $clog2(MAX_HOLD + 1);
  // One extra bit so last_id + 1 + offset never overflows before wrapping.
  localparam int unsigned START_W = ID_W + 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_REQ - 1);
  localparam logic [START_W-1:0] NUM_REQ_S = START_W'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q,    id_d;
  logic [HOLD_W-1:0]    hold_q,  hold_d;
  logic [ID_W-1:0]      last_q,  last_d;

  logic                 owner_req_c;
  logic                 others_c;
  logic                 any_req_c;
  logic                 at_max_c;
  logic [ID_W-1:0]      search_base_c;
  logic [ID_W-1:0]      winner_c;

  // Round-robin pick: first set bit of r searching from base+1 upward with wrap.
  // The request vector is rotated so the search start lands on bit 0, then the
  // lowest set bit is mapped back to an absolute index.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    base);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   sh;
    logic [START_W-1:0]   start;
    logic [START_W-1:0]   idx;
    logic                 found;
    logic [ID_W-1:0]      win;
    start = START_W'(base) + START_W'(1);
    dbl   = {r, r};
    rot   = NUM_REQ'(dbl >> start);
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      sh = rot >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = start + START_W'(j);
        if (idx >= NUM_REQ_S) begin
          idx = idx - NUM_REQ_S;
        end
        win = ID_W'(idx);
      end
    end
    return win;
  endfunction

  // Request classification relative to the current owner.
  always_comb begin
    owner_req_c = |(req & grant_q);
    others_c    = |(req & ~grant_q);
    any_req_c   = |req;
    at_max_c    = (hold_q == HOLD_MAX);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_req_c && (!at_max_c || !others_c)) begin
          state_d = ST_GRANT;
        end else if (!owner_req_c && others_c) begin
          state_d = ST_GRANT;
        end else if (!owner_req_c) begin
          state_d = ST_IDLE;
        end else begin
          // Owner still requesting but has used its full hold while others wait.
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = any_req_c ? ST_GRANT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A departing owner becomes the round-robin reference; otherwise last_id holds.
  always_comb begin
    search_base_c = (state_q == ST_GRANT) ? id_q : last_q;
    winner_c      = rr_pick(req, search_base_c);
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    grant_d = '0;
    valid_d = 1'b0;
    id_d    = '0;
    hold_d  = '0;
    last_d  = last_q;
    if (state_d == ST_GRANT) begin
      valid_d = 1'b1;
      if ((state_q == ST_GRANT) && owner_req_c) begin
        grant_d = grant_q;
        id_d    = id_q;
        hold_d  = at_max_c ? hold_q : (hold_q + HOLD_ONE);
      end else begin
        grant_d = NUM_REQ'(1) << winner_c;
        id_d    = winner_c;
        hold_d  = HOLD_ONE;
        if (state_q == ST_GRANT) begin
          last_d = id_q;
        end
      end
    end else if (state_q == ST_GRANT) begin
      last_d = id_q;
    end
  end

  // Registered outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      hold_q  <= '0;
      last_q  <= LAST_RST;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_rr_req_grant_arbiter.sv
// tb_rr_req_grant_arbiter
//   Directed and random stimulus for rr_req_grant_arbiter (NUM_REQ=4,
//   MAX_HOLD=8) checked against a behavioural owner/last/hold model.
module tb_rr_req_grant_arbiter;

  localparam int N   = 4;
  localparam int MAX = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] hold_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: owner index (-1 = nobody), last owner, hold count.
  int m_owner;
  int m_last;
  int m_hold;

  rr_req_grant_arbiter #(
    .NUM_REQ (4),
    .MAX_HOLD(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .hold_cnt   (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int winner(input logic [3:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_hold  = 0;
  endtask

  // Idle and the post-revoke gap behave identically on the following edge.
  task automatic model_update(input logic [3:0] r);
    logic [3:0] others;
    if (m_owner < 0) begin
      if (r != 4'd0) begin
        m_owner = winner(r, m_last);
        m_hold  = 1;
      end
    end else begin
      others = r & ~(4'(1) << m_owner);
      if (r[m_owner] && (m_hold < MAX || others == 4'd0)) begin
        m_hold = (m_hold < MAX) ? m_hold + 1 : MAX;
      end else begin
        m_last = m_owner;
        if (!r[m_owner] && others != 4'd0) begin
          m_owner = winner(r, m_last);
          m_hold  = 1;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_valid"}, 32'(grant_valid), 32'd0);
    check({tag, "_id"},    32'(grant_id), 32'd0);
    check({tag, "_hold"},  32'(hold_cnt), 32'd0);
  endtask

  // Drive r at the negedge, let the DUT sample it, compare #1 after the posedge.
  task automatic step(input logic [3:0] r);
    logic [3:0] eg;
    @(negedge clk);
    req = r;
    model_update(r);
    eg = (m_owner < 0) ? 4'd0 : (4'(1) << m_owner);
    @(posedge clk);
    #1;
    check("grant",       32'(grant), 32'(eg));
    check("grant_valid", 32'(grant_valid), 32'(eg != 4'd0));
    check("grant_id",    32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("hold_cnt",    32'(hold_cnt), 32'(m_hold));
    check("onehot0",     32'($onehot0(grant)), 32'd1);
    check("past_req",    32'(grant & ~r), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'd0;
    #1;
    check_idle("rst_pulse");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int         seq[5];
    int         exp_seq[5];
    logic [3:0] r;

    exp_seq = '{0, 1, 2, 3, 0};
    model_reset();

    // Reset held for 3 cycles with every requester active.
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1;
    req   = 4'b0000;

    // Lone requester: one-cycle latency, hold saturates at MAX_HOLD.
    step(4'b0000);
    step(4'b0001);
    check("first_grant", 32'(grant), 32'b0001);
    repeat (11) step(4'b0001);
    check("hold_sat", 32'(hold_cnt), 32'(MAX));

    // Asynchronous reset between edges clears a live grant immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
    model_reset();

    // Round-robin handoffs: each owner drops after two cycles, then reasserts.
    step(4'b1111);
    seq[0] = int'(grant_id);
    for (int i = 1; i < 5; i++) begin
      step(4'b1111);
      step(4'b1111 & ~(4'(1) << m_owner));
      check("rr_no_gap", 32'(grant_valid), 32'd1);
      seq[i] = int'(grant_id);
    end
    for (int i = 0; i < 5; i++) begin
      check("rr_order", 32'(seq[i]), 32'(exp_seq[i]));
    end

    // Forced revoke with two constant requesters.
    do_reset();
    repeat (40) step(4'b0011);

    // Release with nothing pending, regrant, then confirm the pointer moved past 2.
    do_reset();
    repeat (3) step(4'b0100);
    repeat (2) step(4'b0000);
    step(4'b0100);
    check("regrant", 32'(grant), 32'b0100);
    step(4'b0000);
    step(4'b1001);
    check("after_last2", 32'(grant), 32'b1000);
    step(4'b0000);

    // Random traffic with persistent request lines.
    do_reset();
    r = 4'd0;
    repeat (2000) begin
      r = r ^ (4'($urandom) & 4'($urandom));
      step(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_req_grant_arbiter.md
Name: rr_req_grant_arbiter

Overview:
Responder side of the team's req/grant handshake. It samples up to NUM_REQ request lines and returns a registered one-hot grant. Arbitration is round-robin with a bounded hold time. Timing is built so that, for a lone requester, the non-overlapping property "req |=> grant" holds and the overlapping property "req |-> grant" fails on the first request cycle.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_HOLD, 8, maximum consecutive grant cycles for one owner while others wait (>=1)
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  request lines, level-sensitive, bit i = requester i
grant  output  NUM_REQ  registered one-hot grant, all-zero when idle
grant_valid  output  1  OR of grant, registered
grant_id  output  ID_W  index of current owner, 0 when grant_valid=0
hold_cnt  output  $clog2(MAX_HOLD+1)  cycles current owner has held grant, saturating

Behaviour:
- Reset (async assert, sync release):
  - grant=0, grant_valid=0, grant_id=0, hold_cnt=0
  - state=IDLE
  - last_id=NUM_REQ-1, so requester 0 has first priority.
- Winner selection: the first set req bit searching from last_id+1 upward, with wrap-around modulo NUM_REQ.
- States:
  - IDLE: no grant.
    - If any req bit is sampled high at edge k, grant the winner at edge k+1. Latency is exactly 1 cycle.
    - Set hold_cnt=1 and move to GRANT.
  - GRANT: owner = grant_id.
    - Owner req high and (hold_cnt < MAX_HOLD, or no other req bit set): keep grant; hold_cnt increments and saturates at MAX_HOLD.
    - Owner req low, other requests pending: hand off at the next edge with no gap. New winner is searched from owner+1. last_id=old owner. hold_cnt=1.
    - Owner req low, no requests: grant=0, go to IDLE, last_id=owner.
    - Owner req high, hold_cnt == MAX_HOLD, other requests pending: forced revoke. grant=0 for exactly one cycle (state GAP), last_id=owner.
  - GAP: grant=0, hold_cnt=0.
    - Next edge: if any req is set, grant the winner (searched from last_id+1) and go to GRANT; otherwise go to IDLE.
    - The revoked owner may be re-granted only if it is the sole requester.
- Grant output never has more than one bit set (one-hot or zero) in any cycle.
- Grant is never asserted to a requester whose req was low at the previous sampling edge.
- Simultaneous owner release and new request: treated as handoff, no idle cycle.
- Reset asserted mid-grant: outputs clear immediately, without waiting for a clock.
- After reset release, the first grant follows the IDLE rule.
- A req pulse of one cycle still earns one grant cycle. Requesters must tolerate a grant that arrives after they drop req.
- grant_id and grant_valid are always consistent with grant in the same cycle.

Test Plan:
- Reset check: rst_n=0 for 3 cycles with req=4'b1111 -> grant=0, grant_valid=0, hold_cnt=0 throughout. Asserting rst_n low between edges clears grant before the next posedge.
- Single requester latency: req=4'b0001 from edge 2 and held -> grant=4'b0001 from edge 3. "req |=> grant" passes every cycle; "req |-> grant" fails at edge 2 only. hold_cnt saturates at 8.
- Round-robin order: req=4'b1111 held, each owner drops req after 2 grant cycles then reasserts -> grant_id sequence 0,1,2,3,0 with no idle cycles between handoffs.
- Forced revoke: req=4'b0011 held constantly -> requester 0 granted for 8 cycles, then 1 cycle of grant=0, then requester 1 for 8 cycles, then a gap, then requester 0.
- Owner release with nothing pending: req=4'b0100 for 3 cycles, then 0 -> grant=4'b0100 for 3 cycles starting one edge late, then 0. Next req=4'b0100 is granted again after 1 cycle. last_id=2 is verified with a follow-up req=4'b1001, which must grant requester 3.
- One-hot invariant: random req for 2000 cycles -> $onehot0(grant) is always true, and grant[i] implies $past(req[i]).
